// File: rtl/axil_led_arb_pkg.sv
// Shared types and constants for the two-port AXI4-Lite LED arbiter.
// Optional watchdog: define LED_ARB_TIMEOUT_EN.
package axil_led_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP
  } arb_state_t;
endpackage

// File: rtl/axil_rr_pick.sv
// Two-input round-robin picker, purely combinational.
// Starts searching at ptr and wraps to the other input.
module axil_rr_pick
  import axil_led_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic               ptr,
  output logic               valid,
  output logic               winner
);
  assign valid  = |elig;
  assign winner = elig[ptr] ? ptr : !ptr;
endmodule

// File: rtl/axil_led_arbiter.sv
// Round-robin AXI4-Lite arbiter (PS = 0, PL = 1) in front of the LED slave.
// Define LED_ARB_TIMEOUT_EN to build the downstream watchdog.
module axil_led_arbiter
  import axil_led_arb_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [2*ADDR_W-1:0]     s_awaddr,
  input  logic [5:0]              s_awprot,
  input  logic [1:0]              s_awvalid,
  output logic [1:0]              s_awready,
  input  logic [2*DATA_W-1:0]     s_wdata,
  input  logic [2*DATA_W/8-1:0]   s_wstrb,
  input  logic [1:0]              s_wvalid,
  output logic [1:0]              s_wready,
  output logic [3:0]              s_bresp,
  output logic [1:0]              s_bvalid,
  input  logic [1:0]              s_bready,
  input  logic [2*ADDR_W-1:0]     s_araddr,
  input  logic [5:0]              s_arprot,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  output logic [2*DATA_W-1:0]     s_rdata,
  output logic [3:0]              s_rresp,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    grant_o,
  output logic                    busy_o,
  output logic                    timeout_o
);
  localparam int SW = DATA_W / 8;

  arb_state_t state, state_n;
  logic grant, grant_n, rr_ptr, ptr_n;
  logic aw_done, aw_done_n, w_done, w_done_n;
  logic [1:0] wr_req, elig;
  logic pick_vld, pick_win;
  logic err, drain, is_wr;
  logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
  logic [1:0] b_rsp, r_rsp;
  logic [DATA_W-1:0] r_dat;

  assign wr_req = s_awvalid & s_wvalid;
  assign elig   = wr_req | s_arvalid;
  assign is_wr  = (state == WRITE) || (state == WRESP);

  axil_rr_pick u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .winner(pick_win)
  );

`ifdef LED_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic tmo, fire;

  assign fire      = (state != IDLE) && !tmo && (cnt == CNT_MAX);
  assign err       = tmo || fire;
  assign timeout_o = fire;
  assign drain     = 1'b1;

  // Watchdog: per-state cycle count, error latch until requester acks
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      if (state_n != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      tmo <= err && (state_n != IDLE);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign err        = 1'b0;
  assign drain      = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // State, grant, pointer and AW/W completion registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr_ptr  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      rr_ptr  <= ptr_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next state and handshake steering for the granted requester
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    ptr_n     = rr_ptr;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_arvalid = 1'b0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    ar_rdy    = 1'b0;
    b_vld     = 1'b0;
    r_vld     = 1'b0;
    b_rsp     = RESP_OKAY;
    r_rsp     = RESP_OKAY;
    r_dat     = '0;
    if (err) begin
      m_bready = 1'b1;
      m_rready = 1'b1;
      if (is_wr) begin
        b_vld = 1'b1;
        b_rsp = RESP_SLVERR;
        if (s_bready[grant]) state_n = IDLE;
      end else begin
        r_vld = 1'b1;
        r_rsp = RESP_SLVERR;
        if (s_rready[grant]) state_n = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          m_bready = drain;
          m_rready = drain;
          if (pick_vld) begin
            grant_n   = pick_win;
            ptr_n     = !pick_win;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = wr_req[pick_win] ? WRITE : READ;
          end
        end
        WRITE: begin
          m_awvalid = !aw_done;
          m_wvalid  = !w_done;
          aw_rdy    = m_awready && !aw_done;
          w_rdy     = m_wready && !w_done;
          if (aw_rdy) aw_done_n = 1'b1;
          if (w_rdy) w_done_n = 1'b1;
          if (aw_done && w_done) state_n = WRESP;
        end
        WRESP: begin
          b_vld    = m_bvalid;
          b_rsp    = m_bresp;
          m_bready = s_bready[grant];
          if (m_bvalid && s_bready[grant]) state_n = IDLE;
        end
        READ: begin
          m_arvalid = 1'b1;
          ar_rdy    = m_arready;
          if (m_arready) state_n = RRESP;
        end
        RRESP: begin
          r_vld    = m_rvalid;
          r_dat    = m_rdata;
          r_rsp    = m_rresp;
          m_rready = s_rready[grant];
          if (m_rvalid && s_rready[grant]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign m_awaddr = grant ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
  assign m_awprot = grant ? s_awprot[5:3] : s_awprot[2:0];
  assign m_wdata  = grant ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
  assign m_wstrb  = grant ? s_wstrb[2*SW-1:SW] : s_wstrb[SW-1:0];
  assign m_araddr = grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
  assign m_arprot = grant ? s_arprot[5:3] : s_arprot[2:0];

  assign s_awready = grant ? {aw_rdy, 1'b0} : {1'b0, aw_rdy};
  assign s_wready  = grant ? {w_rdy, 1'b0} : {1'b0, w_rdy};
  assign s_arready = grant ? {ar_rdy, 1'b0} : {1'b0, ar_rdy};
  assign s_bvalid  = grant ? {b_vld, 1'b0} : {1'b0, b_vld};
  assign s_rvalid  = grant ? {r_vld, 1'b0} : {1'b0, r_vld};
  assign s_bresp   = grant ? {b_rsp, 2'b00} : {2'b00, b_rsp};
  assign s_rresp   = grant ? {r_rsp, 2'b00} : {2'b00, r_rsp};
  assign s_rdata   = grant ? {r_dat, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, r_dat};

  assign grant_o = grant;
  assign busy_o  = (state != IDLE);
endmodule
